// File: rtl/ahb_decoder_pipe.sv
// rtl/ahb_decoder_pipe.sv - AHB-Lite N-slave address decoder with burst lock, data-phase select and error counter
// Optional feature macro: AHB_DEC_REMAP_EN (slave 0 / REMAP_IDX swap)
module ahb_decoder_pipe #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int SLAVE_NUM      = 4,
  parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] SLV_LOW_ADDR  = {SLAVE_NUM{32'h0}},
  parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] SLV_HIGH_ADDR = {SLAVE_NUM{32'h0}},
  parameter int REMAP_IDX      = 1,
  parameter int ERR_CNT_W      = 16
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]                htrans,
  input  logic                      hready,
  input  logic                      hremap,
  input  logic                      err_cnt_clr,
  output logic [SLAVE_NUM-1:0]      hreq,
  output logic                      default_slv_sel,
  output logic [SLAVE_NUM:0]        hsel_data,
  output logic [1:0]                dec_state,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SLVSEL = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  state_t               state_q;
  logic [SLAVE_NUM:0]   lock_sel;
  logic [SLAVE_NUM-1:0] raw_hit;
  logic [SLAVE_NUM-1:0] hit;
  logic                 miss;
  logic                 new_decode;
  logic                 xfer;

  // A SEQ/BUSY seen while idle is an illegal burst start and decodes like NONSEQ.
  assign new_decode = (htrans == TR_NONSEQ) || ((htrans != TR_IDLE) && (state_q == ST_IDLE));
  assign xfer       = new_decode || (htrans == TR_SEQ);

  always_comb begin
    logic found;
    raw_hit = '0;
    found   = 1'b0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      if (!found &&
          (haddr >= SLV_LOW_ADDR[i*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH]) &&
          (haddr <= SLV_HIGH_ADDR[i*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH])) begin
        raw_hit[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

`ifdef AHB_DEC_REMAP_EN
  logic remap_q;
  logic remap_eff;

  // A fresh decode uses the live request; locked beats never re-decode.
  assign remap_eff = new_decode ? hremap : remap_q;

  always_comb begin
    hit = raw_hit;
    if (remap_eff) begin
      hit[0]         = raw_hit[REMAP_IDX];
      hit[REMAP_IDX] = raw_hit[0];
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      remap_q <= 1'b0;
    end else if (hready && (new_decode || (state_q == ST_IDLE))) begin
      remap_q <= hremap;
    end
  end
`else
  localparam int unused_remap_idx = REMAP_IDX;
  logic unused_remap;
  assign unused_remap = hremap;
  assign hit          = raw_hit;
`endif

  assign miss = ~|hit;

  always_comb begin
    hreq            = '0;
    default_slv_sel = 1'b0;
    if (htrans == TR_IDLE) begin
      hreq            = '0;
      default_slv_sel = 1'b0;
    end else if (new_decode) begin
      hreq            = hit;
      default_slv_sel = miss;
    end else begin
      hreq            = lock_sel[SLAVE_NUM-1:0];
      default_slv_sel = lock_sel[SLAVE_NUM];
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q   <= ST_IDLE;
      lock_sel  <= '0;
      hsel_data <= '0;
      err_cnt   <= '0;
    end else begin
      if (hready) begin
        hsel_data <= {default_slv_sel, hreq};
        if (htrans == TR_IDLE) begin
          state_q <= ST_IDLE;
        end else if (new_decode) begin
          state_q  <= miss ? ST_ERROR : ST_SLVSEL;
          lock_sel <= {miss, hit};
        end
      end
      if (err_cnt_clr) begin
        err_cnt <= '0;
      end else if (hready && xfer && default_slv_sel && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign dec_state = state_q;

endmodule
